// File: rtl/pspin_stdout_fifo.sv
// Stdout producer: round-robin arbiter over NUM_SRC word sources feeding a FWFT FIFO.
// Optional PSPIN_STDOUT_DROP_EN: keep granting when full and count the discarded words.
module pspin_stdout_fifo #(
  parameter int NUM_SRC   = 4,
  parameter int DEPTH     = 512,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     src_valid,
  output logic [NUM_SRC-1:0]     src_ready,
  input  logic [NUM_SRC*32-1:0]  src_data,
  input  logic                   stdout_rd_en,
  output logic [31:0]            stdout_dout,
  output logic                   stdout_data_valid,
  output logic [CNT_WIDTH-1:0]   fill_level,
  output logic [31:0]            drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [31:0]          mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0] count;
  logic [SW-1:0]        last_grant;

  logic          full, empty, permit, gnt_vld, gnt_ok, push, pop;
  logic [SW-1:0] gnt_idx, cidx;
  logic [31:0]   gnt_data;
  int            cand;

  assign full  = (count == CNT_WIDTH'(DEPTH));
  assign empty = (count == '0);

  // Search starts just after the last granted source so every source gets a turn.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = last_grant;
    cand    = 0;
    cidx    = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      cidx = SW'(cand);
      if (!gnt_vld && src_valid[cidx]) begin
        gnt_vld = 1'b1;
        gnt_idx = cidx;
      end
    end
  end

`ifdef PSPIN_STDOUT_DROP_EN
  assign permit = 1'b1;
`else
  assign permit = !full;
`endif

  // Fullness is judged before any same-cycle pop, so a pop never makes room for a push.
  assign gnt_ok    = gnt_vld && permit && !rst;
  assign push      = gnt_ok && !full;
  assign pop       = stdout_rd_en && !empty;
  assign gnt_data  = src_data[32*gnt_idx +: 32];
  assign src_ready = gnt_ok ? (NUM_SRC'(1) << gnt_idx) : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= gnt_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= SW'(NUM_SRC - 1);
    end else begin
      if (push)   wr_ptr     <= wr_ptr + 1'b1;
      if (pop)    rd_ptr     <= rd_ptr + 1'b1;
      if (gnt_ok) last_grant <= gnt_idx;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign stdout_dout       = empty ? 32'h0 : mem[rd_ptr];
  assign stdout_data_valid = !empty;
  assign fill_level        = count;

`ifdef PSPIN_STDOUT_DROP_EN
  logic        drop;
  logic [31:0] drop_cnt;

  assign drop = gnt_ok && full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 drop_cnt <= '0;
    else if (drop && drop_cnt != 32'hFFFF_FFFF) drop_cnt <= drop_cnt + 1'b1;
  end

  assign drop_count = drop_cnt;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_pspin_stdout_fifo.sv
// Scoreboard bench for pspin_stdout_fifo: per-source pending queues, a grant model and
// an expected-FIFO queue checked against the DUT every cycle.
module tb_pspin_stdout_fifo;

  localparam int NUM_SRC   = 4;
  localparam int DEPTH     = 512;
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1;
`ifdef PSPIN_STDOUT_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic                  clk, rst;
  logic [NUM_SRC-1:0]    src_valid, src_ready;
  logic [NUM_SRC*32-1:0] src_data;
  logic                  stdout_rd_en, stdout_data_valid;
  logic [31:0]           stdout_dout, drop_count;
  logic [CNT_WIDTH-1:0]  fill_level;

  pspin_stdout_fifo #(.NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .stdout_rd_en(stdout_rd_en), .stdout_dout(stdout_dout),
    .stdout_data_valid(stdout_data_valid), .fill_level(fill_level),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] src_q [NUM_SRC][$];
  logic [31:0] exp_q [$];
  int          m_last = NUM_SRC - 1;
  logic [31:0] m_drop = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit srcs_pending();
    for (int i = 0; i < NUM_SRC; i++) if (src_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // One cycle, entered and left at negedge: drive, check, clock, update model.
  task automatic tick(input logic rd);
    int               g;
    int               idx;
    logic [NUM_SRC-1:0] er;
    logic [31:0]      w;
    bit               full_pre;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_valid[i]         = (src_q[i].size() != 0);
      src_data[32*i +: 32] = src_valid[i] ? src_q[i][0] : 32'h0;
    end
    stdout_rd_en = rd;
    #1;
    full_pre = (exp_q.size() == DEPTH);
    g = -1;
    if (DROP || !full_pre)
      for (int k = 1; k <= NUM_SRC; k++) begin
        idx = (m_last + k) % NUM_SRC;
        if (g < 0 && src_valid[idx]) g = idx;
      end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("src_ready", 32'(src_ready), 32'(er));
    chk("data_valid", 32'(stdout_data_valid), 32'(exp_q.size() != 0));
    chk("dout", stdout_dout, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
    chk("fill_level", 32'(fill_level), 32'(exp_q.size()));
    chk("drop_count", drop_count, m_drop);
    @(posedge clk);
    if (rd && exp_q.size() != 0) void'(exp_q.pop_front());
    if (g >= 0) begin
      w = src_q[g].pop_front();
      m_last = g;
      if (full_pre) m_drop++;
      else          exp_q.push_back(w);
    end
    @(negedge clk);
  endtask

  task automatic run_until_idle(input logic rd, input int limit);
    int n = 0;
    while (srcs_pending() && n < limit) begin tick(rd); n++; end
    chk("idle_timeout", 32'(srcs_pending()), 32'h0);
  endtask

  task automatic drain_to(input int target, input int limit);
    int n = 0;
    while (exp_q.size() > target && n < limit) begin tick(1'b1); n++; end
    chk("drain_timeout", 32'(exp_q.size()), 32'(target));
  endtask

  initial begin
    rst = 1'b1; src_valid = '0; src_data = '0; stdout_rd_en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(src_ready), 32'h0);
    chk("rst_valid", 32'(stdout_data_valid), 32'h0);
    chk("rst_dout", stdout_dout, 32'h0);
    chk("rst_fill", 32'(fill_level), 32'h0);
    chk("rst_drop", drop_count, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // rd_en while empty is ignored
    tick(1'b1);
    tick(1'b0);

    // single word from source 2, visible next cycle, popped by a one-cycle read
    src_q[2].push_back(32'hDEAD_BEEF);
    tick(1'b0);
    tick(1'b1);
    tick(1'b0);

    // all sources contend with distinct words; grants rotate, pops follow grant order
    for (int i = 0; i < NUM_SRC; i++)
      for (int j = 0; j < 3; j++) src_q[i].push_back(32'hA000_0000 | (i << 8) | j);
    run_until_idle(1'b0, 100);
    drain_to(0, 100);
    tick(1'b0);

    // fill to DEPTH, then contend at full with and without a pop
    for (int j = 0; j < DEPTH; j++) src_q[0].push_back(32'h1000_0000 + j);
    run_until_idle(1'b0, DEPTH + 50);
    tick(1'b0);
    for (int j = 0; j < 3; j++) src_q[1].push_back(32'hB000_0000 + j);
    repeat (3) tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);

    // leave 100 words buffered, then reset mid-operation
    for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
    drain_to(100, DEPTH + 50);
    src_valid = '0; stdout_rd_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_fill", 32'(fill_level), 32'h0);
    chk("mid_rst_valid", 32'(stdout_data_valid), 32'h0);
    chk("mid_rst_dout", stdout_dout, 32'h0);
    chk("mid_rst_ready", 32'(src_ready), 32'h0);
    exp_q.delete();
    m_last = NUM_SRC - 1;
    m_drop = 0;
    @(negedge clk);
    rst = 1'b0;

    // source 0 has priority again after reset
    for (int i = 0; i < NUM_SRC; i++) src_q[i].push_back(32'hC000_0000 + i);
    run_until_idle(1'b0, 50);
    drain_to(0, 50);
    tick(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
